// File: rtl/burst_mem_pkg.sv
// rtl/burst_mem_pkg.sv - shared types, defaults and helpers for burst_mem
package burst_mem_pkg;

  localparam int unsigned DEF_ADDR_LEN       = 11;
  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_LINE_WORDS_LOG = 3;
  localparam int unsigned DEF_LATENCY        = 4;
  localparam int unsigned BYTE_W             = 8;

  function automatic int unsigned line_words(input int unsigned log2_words);
    return 1 << log2_words;
  endfunction

  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

  function automatic bit latency_ok(input int unsigned latency);
    return latency >= 1;
  endfunction

  localparam int unsigned LINE_WORDS = line_words(DEF_LINE_WORDS_LOG);
  localparam int unsigned BE_W       = be_width(DEF_DATA_W);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RD   = 2'd2;
  localparam state_t ST_WR   = 2'd3;

endpackage

// File: rtl/burst_mem_if.sv
// rtl/burst_mem_if.sv - request, write-beat and read-beat bundle of burst_mem
interface burst_mem_if
  import burst_mem_pkg::*;
#(
  parameter int unsigned ADDR_LEN = DEF_ADDR_LEN,
  parameter int unsigned DATA_W   = DEF_DATA_W
);
  logic                          req_valid;
  logic                          req_ready;
  logic                          req_we;
  logic [ADDR_LEN-1:0]           req_addr;
  logic                          wr_valid;
  logic                          wr_ready;
  logic [DATA_W-1:0]             wr_data;
  logic [be_width(DATA_W)-1:0]   wr_be;
  logic                          rd_valid;
  logic [DATA_W-1:0]             rd_data;
  logic                          rd_last;

  modport master (
    output req_valid, req_we, req_addr, wr_valid, wr_data, wr_be,
    input  req_ready, wr_ready, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  req_valid, req_we, req_addr, wr_valid, wr_data, wr_be,
    output req_ready, wr_ready, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/burst_mem_mem_bank.sv
// rtl/burst_mem_mem_bank.sv - single-port byte-writable array with registered read
module mem_bank
  import burst_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_LEN,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NBYTES = BE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [NBYTES-1:0] be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  // The array itself is never reset: contents survive a controller reset.
  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (be_i[b]) mem_q[addr_i][BYTE_W*b +: BYTE_W] <= wdata_i[BYTE_W*b +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/burst_mem.sv
// rtl/burst_mem.sv - line-burst memory model with latency, byte enables and wrapping reads
module burst_mem
  import burst_mem_pkg::*;
#(
  parameter int unsigned ADDR_LEN       = DEF_ADDR_LEN,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned LINE_WORDS_LOG = DEF_LINE_WORDS_LOG,
  parameter int unsigned LATENCY        = DEF_LATENCY
) (
  input  logic       clk,
  input  logic       rst,
  burst_mem_if.slave mem_if
);
  localparam int unsigned N     = line_words(LINE_WORDS_LOG);
  localparam int unsigned BW    = be_width(DATA_W);
  localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned LINE_W = ADDR_LEN - LINE_WORDS_LOG;
  localparam logic [LAT_W-1:0]          LAT_LOAD  = LAT_W'(LATENCY - 1);
  localparam logic [LINE_WORDS_LOG-1:0] LAST_BEAT = LINE_WORDS_LOG'(N - 1);
  localparam logic [LINE_WORDS_LOG-1:0] ONE_BEAT  = LINE_WORDS_LOG'(1);

  if (!latency_ok(LATENCY)) begin : g_latency_check
    $error("burst_mem: LATENCY must be at least 1");
  end

  state_t                    state_q, state_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic [LINE_WORDS_LOG-1:0] beat_q, beat_d;
  logic [LINE_WORDS_LOG-1:0] off_q, off_d;
  logic [LINE_W-1:0]         line_q, line_d;
  logic                      we_q, we_d;
  logic                      rd_valid_q, rd_last_q;
  logic                      rd_en, wr_en;
  logic [LINE_WORDS_LOG-1:0] rd_idx, idx;
  logic [ADDR_LEN-1:0]       bank_addr;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    off_d   = off_q;
    line_d  = line_q;
    we_d    = we_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_if.req_valid) begin
          line_d  = mem_if.req_addr[ADDR_LEN-1:LINE_WORDS_LOG];
          off_d   = mem_if.req_addr[LINE_WORDS_LOG-1:0];
          we_d    = mem_if.req_we;
          lat_d   = LAT_LOAD;
          beat_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) state_d = we_q ? ST_WR : ST_RD;
        else             lat_d   = lat_q - LAT_W'(1);
      end
      ST_RD: begin
        beat_d = beat_q + ONE_BEAT;
        if (beat_q == LAST_BEAT) state_d = ST_IDLE;
      end
      ST_WR: begin
        if (mem_if.wr_valid) begin
          beat_d = beat_q + ONE_BEAT;
          if (beat_q == LAST_BEAT) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads are issued one cycle ahead of the beat they feed, so the array
  // sees beat 0 in the last WAIT cycle and beat k+1 while beat k is on rd_data.
  assign rd_idx    = (state_q == ST_RD) ? beat_q + ONE_BEAT : '0;
  assign rd_en     = !we_q && ((state_q == ST_WAIT && lat_q == '0) ||
                               (state_q == ST_RD && beat_q != LAST_BEAT));
  assign wr_en     = (state_q == ST_WR) && mem_if.wr_valid;
  assign idx       = (state_q == ST_WR) ? beat_q : rd_idx;
  assign bank_addr = {line_q, off_q + idx};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lat_q      <= '0;
      beat_q     <= '0;
      off_q      <= '0;
      line_q     <= '0;
      we_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      beat_q     <= beat_d;
      off_q      <= off_d;
      line_q     <= line_d;
      we_q       <= we_d;
      rd_valid_q <= rd_en;
      rd_last_q  <= rd_en && (rd_idx == LAST_BEAT);
    end
  end

  mem_bank #(
    .ADDR_W (ADDR_LEN),
    .DATA_W (DATA_W),
    .NBYTES (BW)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .en_i    (rd_en),
    .we_i    (wr_en),
    .be_i    (mem_if.wr_be),
    .addr_i  (bank_addr),
    .wdata_i (mem_if.wr_data),
    .rdata_o (mem_if.rd_data)
  );

  assign mem_if.req_ready = (state_q == ST_IDLE);
  assign mem_if.wr_ready  = (state_q == ST_WR);
  assign mem_if.rd_valid  = rd_valid_q;
  assign mem_if.rd_last   = rd_last_q;
endmodule

// File: tb/tb_burst_mem.sv
// tb/tb_burst_mem.sv - randomized self-checking bench for burst_mem
module tb_burst_mem;
  import burst_mem_pkg::*;

  localparam int AL  = 11;
  localparam int DW  = 32;
  localparam int LWL = 3;
  localparam int LAT = 4;
  localparam int N   = LINE_WORDS;
  localparam int NB  = BE_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  burst_mem_if #(.ADDR_LEN(AL), .DATA_W(DW)) bus ();

  burst_mem #(
    .ADDR_LEN(AL), .DATA_W(DW), .LINE_WORDS_LOG(LWL), .LATENCY(LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mem_if (bus)
  );

  int checks = 0;
  int fails  = 0;
  logic [DW-1:0] ref_mem [0:(1<<AL)-1];
  logic [DW-1:0] wdat [N];
  logic [NB-1:0] wbe  [N];
  logic [DW-1:0] first_beat;

  // Word address of beat i of a burst starting at a: wraps inside the line.
  function automatic logic [AL-1:0] beat_addr(input logic [AL-1:0] a, input int i);
    int base;
    base = int'(a) - (int'(a) % N);
    return AL'(base + ((int'(a) + i) % N));
  endfunction

  function automatic void model_write(input logic [AL-1:0] a, input int i);
    for (int b = 0; b < NB; b++)
      if (wbe[i][b]) ref_mem[a][8*b +: 8] = wdat[i][8*b +: 8];
  endfunction

  task automatic issue_req(input logic we, input logic [AL-1:0] addr, input logic hold);
    int guard = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready) begin
      checks++; fails++;
      $display("FAIL req_accept timeout req_ready=%b want 1", bus.req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic check_read(input logic [AL-1:0] addr, input string tag, input int stop_k);
    logic [2:0]    exp_flags;
    logic [DW-1:0] exp_data;
    issue_req(1'b0, addr, 1'b0);
    for (int k = 0; k <= LAT + N; k++) begin
      exp_flags = {k >= LAT && k < LAT + N, k == LAT + N - 1, k >= LAT + N};
      checks++;
      if ({bus.rd_valid, bus.rd_last, bus.req_ready} !== exp_flags) begin
        fails++;
        $display("FAIL %s_flags k=%0d got %b want %b", tag, k,
                 {bus.rd_valid, bus.rd_last, bus.req_ready}, exp_flags);
      end
      if (k >= LAT) begin
        exp_data = ref_mem[beat_addr(addr, (k < LAT + N) ? k - LAT : N - 1)];
        checks++;
        if (bus.rd_data !== exp_data) begin
          fails++;
          $display("FAIL %s_data k=%0d got %h want %h", tag, k, bus.rd_data, exp_data);
        end
        if (k == LAT) first_beat = bus.rd_data;
      end
      if (k == stop_k) return;
      @(negedge clk);
    end
  endtask

  task automatic write_burst(input logic [AL-1:0] addr, input string tag,
                             input int gap_after, input int gap_len);
    int   acc = 0;
    int   gap_used = 0;
    int   k = 0;
    logic drive;
    issue_req(1'b1, addr, 1'b0);
    while (acc < N && k < 60) begin
      checks++;
      if ({bus.wr_ready, bus.req_ready} !== {k >= LAT, 1'b0}) begin
        fails++;
        $display("FAIL %s_wr_flags k=%0d got %b want %b", tag, k,
                 {bus.wr_ready, bus.req_ready}, {k >= LAT, 1'b0});
      end
      drive = !(acc == gap_after && gap_used < gap_len && bus.wr_ready);
      if (!drive) gap_used++;
      bus.wr_valid = drive;
      bus.wr_data  = drive ? wdat[acc] : $urandom;
      bus.wr_be    = drive ? wbe[acc] : {NB{1'b1}};
      if (drive && bus.wr_ready) begin
        model_write(beat_addr(addr, acc), acc);
        acc++;
      end
      @(negedge clk);
      k++;
    end
    bus.wr_valid = 1'b0;
    checks++;
    if ({bus.wr_ready, bus.req_ready, acc == N} !== 3'b011) begin
      fails++;
      $display("FAIL %s_wr_end got wr_ready=%b req_ready=%b beats=%0d want 0 1 %0d",
               tag, bus.wr_ready, bus.req_ready, acc, N);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.rd_data} !== {4'b1000, {DW{1'b0}}}) begin
      fails++;
      $display("FAIL reset_state got rr=%b wr=%b rv=%b rl=%b rd=%h want 1 0 0 0 0",
               bus.req_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.rd_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_burst_rw();
    for (int i = 0; i < N; i++) begin
      wdat[i] = 32'h1000_0000 + i;
      wbe[i]  = 4'hF;
    end
    write_burst(11'h010, "wr_line10", N, 0);
    check_read(11'h010, "rd_line10", -1);
    checks++;
    if (first_beat !== 32'h1000_0000) begin
      fails++;
      $display("FAIL rd_line10_first got %h want 10000000", first_beat);
    end
  endtask

  task automatic test_wrap_read();
    check_read(11'h015, "rd_wrap15", -1);
    checks++;
    if (first_beat !== 32'h1000_0005) begin
      fails++;
      $display("FAIL rd_wrap15_first got %h want 10000005", first_beat);
    end
  endtask

  task automatic test_byte_enable();
    for (int i = 0; i < N; i++) begin
      wdat[i] = $urandom;
      wbe[i]  = 4'hF;
    end
    wdat[0] = 32'h1122_3344;
    write_burst(11'h020, "wr_line20", N, 0);
    for (int i = 0; i < N; i++) begin
      wdat[i] = $urandom;
      wbe[i]  = 4'h0;
    end
    wdat[0] = 32'hAABB_CCDD;
    wbe[0]  = 4'b0101;
    write_burst(11'h020, "wr_be20", N, 0);
    check_read(11'h020, "rd_be20", -1);
    checks++;
    if (first_beat !== 32'h11BB_33DD) begin
      fails++;
      $display("FAIL rd_be20_first got %h want 11bb33dd", first_beat);
    end
  endtask

  task automatic test_write_gaps();
    for (int i = 0; i < N; i++) begin
      wdat[i] = $urandom;
      wbe[i]  = 4'hF;
    end
    write_burst(11'h032, "wr_gap", 3, 3);
    check_read(11'h030, "rd_gap", -1);
  endtask

  task automatic test_reset_mid();
    check_read(11'h010, "rd_pre_rst", LAT + 2);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.rd_valid, bus.rd_last, bus.req_ready, bus.wr_ready, bus.rd_data} !== {4'b0010, {DW{1'b0}}}) begin
      fails++;
      $display("FAIL rst_mid got rv=%b rl=%b rr=%b wr=%b rd=%h want 0 0 1 0 0",
               bus.rd_valid, bus.rd_last, bus.req_ready, bus.wr_ready, bus.rd_data);
    end
    @(negedge clk);
    rst = 1'b0;
    check_read(11'h010, "rd_post_rst", -1);
  endtask

  task automatic test_back_to_back();
    logic [AL-1:0] a0 = 11'h010;
    logic [AL-1:0] a1 = 11'h023;
    logic [2:0]    exp_flags;
    logic [DW-1:0] exp_data;
    logic          vis;
    issue_req(1'b0, a0, 1'b1);
    for (int k = 0; k <= 2 * LAT + 2 * N + 1; k++) begin
      if (k == 6) bus.req_addr = a1;
      vis = (k >= LAT && k < LAT + N) || (k >= 2 * LAT + N + 1 && k < 2 * LAT + 2 * N + 1);
      exp_flags = {vis, k == LAT + N - 1 || k == 2 * LAT + 2 * N,
                   k == LAT + N || k == 2 * LAT + 2 * N + 1};
      checks++;
      if ({bus.rd_valid, bus.rd_last, bus.req_ready} !== exp_flags) begin
        fails++;
        $display("FAIL b2b_flags k=%0d got %b want %b", k,
                 {bus.rd_valid, bus.rd_last, bus.req_ready}, exp_flags);
      end
      if (vis) begin
        exp_data = (k < LAT + N) ? ref_mem[beat_addr(a0, k - LAT)]
                                 : ref_mem[beat_addr(a1, k - 2 * LAT - N - 1)];
        checks++;
        if (bus.rd_data !== exp_data) begin
          fails++;
          $display("FAIL b2b_data k=%0d got %h want %h", k, bus.rd_data, exp_data);
        end
      end
      if (k == LAT + N + 1) bus.req_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [AL-1:0] a;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < N; i++) begin
        wdat[i] = $urandom;
        wbe[i]  = 4'hF;
      end
      write_burst(AL'(11'h040 + 8 * j), "wr_init", N, 0);
    end
    for (int r = 0; r < 16; r++) begin
      a = AL'(11'h040 + $urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < N; i++) begin
          wdat[i] = $urandom;
          wbe[i]  = NB'($urandom_range(0, 15));
        end
        write_burst(a, "wr_rand", $urandom_range(0, N), $urandom_range(0, 3));
      end else begin
        check_read(a, "rd_rand", -1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.wr_be     = '0;
    test_reset();
    test_burst_rw();
    test_wrap_read();
    test_byte_enable();
    test_write_gaps();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/burst_mem.md
# burst_mem

Parametrised word-addressed main-memory model for the cache datapath. It serves whole cache lines as fixed-length bursts behind a valid/ready request handshake, with a configurable access latency. Writes use per-byte enables. Reads are critical-word-first and wrap within the line. It sits below the cache controller and replaces the single-word, fixed-latency memory for refill and write-back traffic.

## Interface
Parameters:
- ADDR_LEN, 11: word-address width; depth is 2^ADDR_LEN words.
- DATA_W, 32: word width; must be a multiple of 8.
- LINE_WORDS_LOG, 3: log2 of words per line and per burst (N = 8).
- LATENCY, 4: cycles from request accept to first data beat or first write slot; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_we  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_LEN  word address of the critical word.
- wr_valid  in  1  write beat present.
- wr_ready  out  1  write slot open.
- wr_data  in  DATA_W  write beat data.
- wr_be  in  DATA_W/8  byte enables for the write beat.
- rd_valid  out  1  read beat valid; there is no backpressure on reads.
- rd_data  out  DATA_W  read beat data.
- rd_last  out  1  marks the final read beat.

## Operation
- FSM states:
  - IDLE: req_ready = 1.
  - WAIT: latency countdown.
  - RD: read beats.
  - WR: write beats.
- Accept: a request is accepted when req_valid & req_ready are both high at a clock edge. On accept, latch the line base (req_addr with the low LINE_WORDS_LOG bits cleared) and the word offset (the low bits). Go to WAIT and load the countdown.
- Beat address = {line base, offset + beat count}, taken modulo N. The burst wraps inside the line and never crosses into the next line.
- RD: N beats, one per cycle. rd_last is high on beat N-1. Return to IDLE after the last beat.
- WR: wr_ready stays high for the whole WR state.
  - A beat is accepted on wr_valid & wr_ready.
  - Only bytes with wr_be set are written; other bytes keep their contents.
  - If wr_valid is low, the beat count holds and no write occurs.
  - Return to IDLE after N accepted beats.
- req_valid outside IDLE is ignored; it is not queued.
- rd_data holds its last value when rd_valid is low.
- Reset:
  - state = IDLE, rd_valid = 0, rd_last = 0, rd_data = 0, wr_ready = 0, counters = 0.
  - req_ready is decoded from state, so it reads 1 while in IDLE; requests are not accepted while rst is high.
  - Memory contents are not cleared.
- Reset mid-burst aborts the burst at once. Beats already written remain in memory.

## Timing
- Accept edge = T0.
- Read: rd_valid is high for cycles T0+LATENCY through T0+LATENCY+N-1; rd_last is high in the final cycle.
- Storage read is synchronous with 1-cycle latency. The first array address is therefore issued at T0+LATENCY-1.
- Write: wr_ready rises at T0+LATENCY. Each beat is written into the array at the edge where it is accepted.
- req_ready rises in the cycle after the last read beat or last accepted write beat. Back-to-back requests incur no extra idle cycle.
- A read issued after a write completes returns the new data.

## Structure
- Package burst_mem_pkg holds:
  - the state enum (IDLE, WAIT, RD, WR);
  - localparams LINE_WORDS = 1<<LINE_WORDS_LOG and BE_W = DATA_W/8;
  - a parameter check that LATENCY >= 1.
- One sub-module, mem_bank: a single-port array with a per-byte write enable and a registered read whose output resets to 0. burst_mem contains the FSM, the latency counter, the beat counter and the address generation.

## Test plan
Default parameters throughout.
1. Write burst to 0x010, data 0x10000000+i, wr_be 4'hF, wr_valid always high. Then read 0x010. Required: rd_valid at T0+4..T0+11 with data 0x10000000..0x10000007; rd_last only on the 8th beat.
2. Read 0x015 after test 1. Required: beats in word order 5,6,7,0,1,2,3,4 of line 0x010, i.e. 0x10000005, 0x10000006, 0x10000007, 0x10000000, 0x10000001, 0x10000002, 0x10000003, 0x10000004.
3. Word 0x020 holds 0x11223344. Write beat 0 with data 0xAABBCCDD and wr_be 4'b0101. Required: reading 0x020 returns 0x11BB33DD.
4. Write burst with wr_valid low for 3 cycles after beat 2. Required: no array write during the gap, exactly 8 writes in total, req_ready low until the 8th accept, then high the next cycle.
5. Assert rst after the 3rd read beat. Required: rd_valid = 0 and rd_data = 0 immediately, FSM in IDLE. A read of the same line afterwards returns the pre-reset contents.
6. req_valid held high through a read, with req_addr changed mid-burst. Required: the mid-burst request is ignored; the next accept happens in the cycle after rd_last, and its first beat arrives 4 cycles later.
